// File: rtl/hazard_pkg.sv
// hazard_pkg: shared state, EX-record type and widths for hazard_ctrl.
package hazard_pkg;
    localparam int CNT_W = 16;
    // EX record stores rd at a fixed maximum width so the struct is parameter-free
    localparam int RD_W = 8;
    typedef enum logic {RUN, FLUSH} ctrl_state_t;
    typedef struct packed {
        logic            valid;
        logic [RD_W-1:0] rd;
        logic            wr_en;
        logic            is_load;
    } ex_rec_t;
endpackage

// File: rtl/hazard_ctrl_fwd_match.sv
// fwd_match: compares one decode source operand against the EX record.
module fwd_match
    import hazard_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic             use_rs,
    input  logic [REG_W-1:0] rs,
    input  ex_rec_t          ex,
    output logic             fwd,
    output logic             load_use
);
    logic match;
    assign match    = use_rs && ex.valid && ex.wr_en && ex.rd != '0 && ex.rd == RD_W'(rs);
    assign fwd      = match && !ex.is_load;
    assign load_use = match && ex.is_load;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: EX-stage forwarding/load-use stall/branch flush controller.
// Define HAZARD_CNT_EN to add saturating stall/flush/forward event counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_W     = 5,
    parameter int FLUSH_CYC = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_wr_en,
    input  logic             id_is_load,
    input  logic             id_a_pc,
    input  logic             id_b_imm,
    input  logic             ex_branch_taken,
    output logic             A1_sel,
    output logic             B1_sel,
    output logic             A2_sel,
    output logic             B2_sel,
    output logic             stall,
    output logic             flush
`ifdef HAZARD_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] fwd_cnt
`endif
);
    ctrl_state_t state;
    logic [2:0]  fcnt;
    ex_rec_t     ex;
    ex_rec_t     id_rec;
    logic        fwd1, fwd2, lu1, lu2, xfer;

    fwd_match #(.REG_W(REG_W)) u_m1 (.use_rs(id_use_rs1), .rs(id_rs1), .ex(ex), .fwd(fwd1), .load_use(lu1));
    fwd_match #(.REG_W(REG_W)) u_m2 (.use_rs(id_use_rs2), .rs(id_rs2), .ex(ex), .fwd(fwd2), .load_use(lu2));

    assign id_rec = '{valid: id_valid, rd: RD_W'(id_rd), wr_en: id_wr_en, is_load: id_is_load};
    // a taken branch overrides a load-use stall and kills the decode slot
    assign stall  = state == RUN && id_valid && (lu1 || lu2) && !ex_branch_taken;
    assign xfer   = state == RUN && !stall && !ex_branch_taken;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= RUN;
            fcnt   <= '0;
            flush  <= 1'b0;
            ex     <= '0;
            A1_sel <= 1'b0;
            B1_sel <= 1'b0;
            A2_sel <= 1'b0;
            B2_sel <= 1'b0;
        end else begin
            ex     <= xfer ? id_rec : '0;
            A1_sel <= xfer && id_valid && fwd1;
            B1_sel <= xfer && id_valid && fwd2;
            A2_sel <= xfer && id_valid && id_a_pc;
            B2_sel <= xfer && id_valid && id_b_imm;
            if (state == RUN) begin
                if (ex_branch_taken) begin
                    state <= FLUSH;
                    fcnt  <= 3'(FLUSH_CYC - 1);
                    flush <= 1'b1;
                end
            end else if (fcnt == '0) begin
                state <= RUN;
                flush <= 1'b0;
            end else begin
                fcnt <= fcnt - 3'd1;
            end
        end
    end

`ifdef HAZARD_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
            fwd_cnt   <= '0;
        end else begin
            stall_cnt <= stall_cnt + CNT_W'(stall && stall_cnt != '1);
            flush_cnt <= flush_cnt + CNT_W'(flush && flush_cnt != '1);
            fwd_cnt   <= fwd_cnt + CNT_W'((A1_sel || B1_sel) && fwd_cnt != '1);
        end
    end
`endif
endmodule
